// File: rtl/temp_sensor.sv
// DS18B20-style 1-wire read sequencer: SKIP_ROM, CONVERT_TEMP, SKIP_ROM, READ_SCRATCH,
// then 16 read slots and a reset slot. Every bus slot is 100 clk cycles, paced by clk_divider.
module temp_sensor (
    input  logic       clk,
    input  logic       rst,
    input  logic       read_request,
    output logic       out_wire,
    output logic [2:0] state,
    output logic [3:0] count_read,
    output logic [3:0] next_read,
    output logic [2:0] count_index,
    output logic [2:0] next_index,
    output logic [6:0] clk_divider,
    output logic       strobe
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        SKIP_ROM     = 3'd1,
        CONVERT_TEMP = 3'd2,
        SKIP_ROM2    = 3'd3,
        READ_SCRATCH = 3'd4,
        READ         = 3'd5,
        RESET        = 3'd6
    } state_e;

    localparam logic [6:0] SLOT_LAST = 7'd99;

    localparam logic [7:0] CMD_SKIP_ROM     = 8'hCC;
    localparam logic [7:0] CMD_CONVERT_TEMP = 8'h44;
    localparam logic [7:0] CMD_READ_SCRATCH = 8'hBE;

    state_e     state_q, state_d;
    logic [2:0] index_q, index_d;
    logic [3:0] read_q,  read_d;
    logic [6:0] div_q,   div_d;
    logic [7:0] cmd_byte;

    // Slot timer: free-running 0..99, held at 0 during reset.
    assign div_d = (div_q == SLOT_LAST) ? 7'd0 : div_q + 7'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= 7'd0;
        end else begin
            div_q <= div_d;
        end
    end

    assign strobe     = (div_q == SLOT_LAST);
    assign next_index = index_q + 3'd1;
    assign next_read  = read_q + 4'd1;

    // State register (only the comb logic below lets it move, and only on strobe).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            index_q <= 3'd0;
            read_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            read_q  <= read_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        read_d  = read_q;
        if (strobe) begin
            case (state_q)
                IDLE: begin
                    if (read_request) begin
                        state_d = SKIP_ROM;
                        index_d = 3'd0;
                    end
                end
                SKIP_ROM, CONVERT_TEMP, SKIP_ROM2, READ_SCRATCH: begin
                    // next_index wraps 7->0, so the new byte starts at bit 0.
                    index_d = next_index;
                    if (index_q == 3'd7) begin
                        case (state_q)
                            SKIP_ROM:     state_d = CONVERT_TEMP;
                            CONVERT_TEMP: state_d = SKIP_ROM2;
                            SKIP_ROM2:    state_d = READ_SCRATCH;
                            default:      state_d = READ;
                        endcase
                    end
                end
                READ: begin
                    read_d = next_read;
                    if (read_q == 4'd15) begin
                        state_d = RESET;
                    end
                end
                RESET: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    index_d = 3'd0;
                    read_d  = 4'd0;
                end
            endcase
        end
    end

    // Output decode: command bits LSB first, bus released in READ, driven low otherwise.
    always_comb begin
        cmd_byte = 8'h00;
        out_wire = 1'b0;
        case (state_q)
            SKIP_ROM, SKIP_ROM2: begin
                cmd_byte = CMD_SKIP_ROM;
                out_wire = cmd_byte[index_q];
            end
            CONVERT_TEMP: begin
                cmd_byte = CMD_CONVERT_TEMP;
                out_wire = cmd_byte[index_q];
            end
            READ_SCRATCH: begin
                cmd_byte = CMD_READ_SCRATCH;
                out_wire = cmd_byte[index_q];
            end
            READ:    out_wire = 1'b1;
            default: out_wire = 1'b0;
        endcase
    end

    assign state       = state_q;
    assign count_index = index_q;
    assign count_read  = read_q;
    assign clk_divider = div_q;

endmodule

// File: tb/tb_temp_sensor.sv
// Directed bench for temp_sensor: reset, first slot, each command byte, read phase,
// restart, async abort and idle strobe cadence, against hand-computed values.
module tb_temp_sensor;

    logic       clk;
    logic       rst;
    logic       read_request;
    logic       out_wire;
    logic [2:0] state;
    logic [3:0] count_read;
    logic [3:0] next_read;
    logic [2:0] count_index;
    logic [2:0] next_index;
    logic [6:0] clk_divider;
    logic       strobe;

    int vectors;
    int miscompares;

    temp_sensor dut (
        .clk         (clk),
        .rst         (rst),
        .read_request(read_request),
        .out_wire    (out_wire),
        .state       (state),
        .count_read  (count_read),
        .next_read   (next_read),
        .count_index (count_index),
        .next_index  (next_index),
        .clk_divider (clk_divider),
        .strobe      (strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one full slot; called from 1 ns after a strobe edge, lands at the same phase.
    task automatic next_slot();
        repeat (100) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        read_request = 1'b1;
        repeat (2000) @(posedge clk);
        @(negedge clk);
        vectors++; if (state !== 3'd0)       begin miscompares++; $display("FAIL reset_state: got %0d want 0", state); end
        vectors++; if (out_wire !== 1'b0)    begin miscompares++; $display("FAIL reset_out_wire: got %b want 0", out_wire); end
        vectors++; if (clk_divider !== 7'd0) begin miscompares++; $display("FAIL reset_divider: got %0d want 0", clk_divider); end
        vectors++; if (strobe !== 1'b0)      begin miscompares++; $display("FAIL reset_strobe: got %b want 0", strobe); end
        vectors++; if (next_index !== 3'd1)  begin miscompares++; $display("FAIL reset_next_index: got %0d want 1", next_index); end
        vectors++; if (next_read !== 4'd1)   begin miscompares++; $display("FAIL reset_next_read: got %0d want 1", next_read); end
        vectors++; if (count_index !== 3'd0 || count_read !== 4'd0) begin
            miscompares++; $display("FAIL reset_counters: got idx %0d rd %0d want 0 0", count_index, count_read);
        end
    endtask

    task automatic test_first_strobe();
        int early;
        early = 0;
        rst = 1'b1;
        for (int i = 1; i <= 99; i++) begin
            @(posedge clk); #1;
            if (i < 99 && (strobe !== 1'b0 || state !== 3'd0)) early++;
        end
        vectors++; if (early != 0) begin miscompares++; $display("FAIL early_strobe: got %0d bad cycles want 0", early); end
        vectors++; if (clk_divider !== 7'd99 || strobe !== 1'b1) begin
            miscompares++; $display("FAIL first_strobe: got div %0d strobe %b want 99 1", clk_divider, strobe);
        end
        @(posedge clk); #1;
        vectors++; if (state !== 3'd1 || count_index !== 3'd0 || clk_divider !== 7'd0) begin
            miscompares++; $display("FAIL accept: got st %0d idx %0d div %0d want 1 0 0", state, count_index, clk_divider);
        end
    endtask

    task automatic test_command(input string name, input logic [2:0] exp_state, input logic [7:0] pattern);
        logic exp_bit;
        for (int b = 0; b < 8; b++) begin
            exp_bit = pattern[b];
            vectors++; if (state !== exp_state || count_index !== 3'(b)) begin
                miscompares++; $display("FAIL %s_state slot %0d: got st %0d idx %0d want %0d %0d", name, b, state, count_index, exp_state, b);
            end
            vectors++; if (out_wire !== exp_bit) begin
                miscompares++; $display("FAIL %s_bit slot %0d: got %b want %b", name, b, out_wire, exp_bit);
            end
            next_slot();
        end
    endtask

    task automatic test_read();
        for (int i = 0; i < 16; i++) begin
            vectors++; if (state !== 3'd5 || count_read !== 4'(i) || out_wire !== 1'b1) begin
                miscompares++; $display("FAIL read slot %0d: got st %0d rd %0d ow %b want 5 %0d 1", i, state, count_read, out_wire, i);
            end
            vectors++; if (next_read !== 4'((i + 1) % 16)) begin
                miscompares++; $display("FAIL next_read slot %0d: got %0d want %0d", i, next_read, (i + 1) % 16);
            end
            next_slot();
        end
        vectors++; if (state !== 3'd6 || out_wire !== 1'b0 || count_read !== 4'd0) begin
            miscompares++; $display("FAIL reset_slot: got st %0d ow %b rd %0d want 6 0 0", state, out_wire, count_read);
        end
        next_slot();
        vectors++; if (state !== 3'd0 || out_wire !== 1'b0) begin
            miscompares++; $display("FAIL back_idle: got st %0d ow %b want 0 0", state, out_wire);
        end
        next_slot();
        vectors++; if (state !== 3'd1 || count_index !== 3'd0) begin
            miscompares++; $display("FAIL restart: got st %0d idx %0d want 1 0", state, count_index);
        end
    endtask

    task automatic test_async_reset();
        repeat (3) next_slot();
        repeat (37) @(posedge clk);
        #1;
        vectors++; if (state !== 3'd2 || count_index !== 3'd3) begin
            miscompares++; $display("FAIL pre_abort: got st %0d idx %0d want 2 3", state, count_index);
        end
        #2 rst = 1'b0;
        #1;
        vectors++; if (state !== 3'd0 || count_index !== 3'd0 || count_read !== 4'd0 || clk_divider !== 7'd0) begin
            miscompares++; $display("FAIL async_abort: got st %0d idx %0d rd %0d div %0d want 0 0 0 0", state, count_index, count_read, clk_divider);
        end
        read_request = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_idle_hold();
        int bad_state;
        int bad_strobe;
        int pulses;
        bad_state = 0; bad_strobe = 0; pulses = 0;
        for (int i = 1; i <= 7000; i++) begin
            @(posedge clk); #1;
            if (state !== 3'd0 || out_wire !== 1'b0) bad_state++;
            if (strobe !== ((i % 100) == 99)) bad_strobe++;
            if (strobe === 1'b1) pulses++;
        end
        vectors++; if (bad_state != 0)  begin miscompares++; $display("FAIL idle_state: got %0d bad cycles want 0", bad_state); end
        vectors++; if (bad_strobe != 0) begin miscompares++; $display("FAIL idle_strobe_phase: got %0d bad cycles want 0", bad_strobe); end
        vectors++; if (pulses != 70)    begin miscompares++; $display("FAIL idle_strobe_count: got %0d want 70", pulses); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        read_request = 1'b0;
        test_reset();
        test_first_strobe();
        test_command("skip_rom", 3'd1, 8'hCC);
        read_request = 1'b0;
        test_command("convert_temp", 3'd2, 8'h44);
        test_command("skip_rom2", 3'd3, 8'hCC);
        read_request = 1'b1;
        test_command("read_scratch", 3'd4, 8'hBE);
        test_read();
        test_command("skip_rom_again", 3'd1, 8'hCC);
        test_async_reset();
        test_idle_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
